// File: rtl/lector_pwrcntr.sv
// Sweeps every PwrCntr address, streams each 32-bit count out on a valid/ready beat, optionally clears it.
// First beat 2 cycles after inicio; 2 cycles/counter (3 with clear). listo low holds the beat indefinitely.
module lector_pwrcntr #(
    parameter int NUM_CNTR = 3,
    parameter int NDIR     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inicio,
    input  logic              borrar,
    output logic [NDIR-1:0]   dir,
    output logic              LE,
    output logic [31:0]       dato_wr,
    output logic              dato_en,
    input  logic [31:0]       dato_rd,
    output logic [31:0]       valor,
    output logic [NDIR-1:0]   valor_dir,
    output logic              valido,
    input  logic              listo,
    output logic [32+NDIR-1:0] total,
    output logic              ocupado,
    output logic              fin
);
    typedef enum logic [2:0] {REPOSO, LEER, ENTREGA, BORRAR, FIN} estado_t;

    localparam logic [NDIR-1:0] ULTIMO = NDIR'(NUM_CNTR - 1);

    estado_t             r_estado;
    estado_t             w_sig;
    logic                r_borrar;
    logic [NDIR-1:0]     r_dir;
    logic                r_le;
    logic                r_dato_en;
    logic [31:0]         r_valor;
    logic [NDIR-1:0]     r_valor_dir;
    logic                r_valido;
    logic [32+NDIR-1:0]  r_total;
    logic                r_ocupado;
    logic                r_fin;
    logic                w_ultimo;
    logic                w_avanza;

    assign w_ultimo = (r_dir == ULTIMO);
    assign w_avanza = (r_estado == ENTREGA && listo && !r_borrar) || (r_estado == BORRAR);

    always_comb begin
        w_sig = r_estado;
        case (r_estado)
            REPOSO:  if (inicio) w_sig = LEER;
            LEER:    w_sig = ENTREGA;
            ENTREGA: if (listo) w_sig = r_borrar ? BORRAR : (w_ultimo ? FIN : LEER);
            BORRAR:  w_sig = w_ultimo ? FIN : LEER;
            FIN:     w_sig = REPOSO;
            default: w_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_estado <= REPOSO;
        else       r_estado <= w_sig;
    end

    // Memory controls are registered from the next state so LE, dato_en and dir all move on one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_borrar    <= 1'b0;
            r_dir       <= '0;
            r_le        <= 1'b1;
            r_dato_en   <= 1'b0;
            r_valor     <= '0;
            r_valor_dir <= '0;
            r_valido    <= 1'b0;
            r_total     <= '0;
            r_ocupado   <= 1'b0;
            r_fin       <= 1'b0;
        end else begin
            r_le      <= (w_sig != BORRAR);
            r_dato_en <= (w_sig == BORRAR);
            r_valido  <= (w_sig == ENTREGA);
            r_fin     <= (w_sig == FIN);
            r_ocupado <= (w_sig != REPOSO);
            if (r_estado == REPOSO && inicio) begin
                r_dir    <= '0;
                r_total  <= '0;
                r_borrar <= borrar;
            end
            if (r_estado == LEER) begin
                r_valor     <= dato_rd;
                r_valor_dir <= r_dir;
                r_total     <= r_total + {{NDIR{1'b0}}, dato_rd};
            end
            if (w_avanza && !w_ultimo)
                r_dir <= r_dir + NDIR'(1);
        end
    end

    assign dir       = r_dir;
    assign LE        = r_le;
    assign dato_wr   = 32'd0;
    assign dato_en   = r_dato_en;
    assign valor     = r_valor;
    assign valor_dir = r_valor_dir;
    assign valido    = r_valido;
    assign total     = r_total;
    assign ocupado   = r_ocupado;
    assign fin       = r_fin;
endmodule

// File: tb/tb_lector_pwrcntr.sv
// Bench for lector_pwrcntr: table-driven sweeps, reset and single-counter sequences, randomized sweeps vs a counter-memory model.
module tb_lector_pwrcntr;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inicio = 1'b0, borrar = 1'b0, listo = 1'b1;
    logic [1:0]  dir;
    logic        LE, dato_en, valido, ocupado, fin;
    logic [31:0] dato_wr, dato_rd, valor;
    logic [1:0]  valor_dir;
    logic [33:0] total;
    logic [31:0] mem [0:3];

    logic        inicio_b = 1'b0, listo_b = 1'b1;
    logic [0:0]  dir_b, valor_dir_b;
    logic        LE_b, dato_en_b, valido_b, ocupado_b, fin_b;
    logic [31:0] dato_wr_b, valor_b;
    logic [31:0] mem_b = 32'd42;
    logic [32:0] total_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign dato_rd = mem[dir];

    lector_pwrcntr #(.NUM_CNTR(3), .NDIR(2)) dut (
        .clk(clk), .reset(reset), .inicio(inicio), .borrar(borrar), .dir(dir), .LE(LE),
        .dato_wr(dato_wr), .dato_en(dato_en), .dato_rd(dato_rd), .valor(valor),
        .valor_dir(valor_dir), .valido(valido), .listo(listo), .total(total),
        .ocupado(ocupado), .fin(fin));

    lector_pwrcntr #(.NUM_CNTR(1), .NDIR(1)) dut_b (
        .clk(clk), .reset(reset), .inicio(inicio_b), .borrar(1'b0), .dir(dir_b), .LE(LE_b),
        .dato_wr(dato_wr_b), .dato_en(dato_en_b), .dato_rd(mem_b), .valor(valor_b),
        .valor_dir(valor_dir_b), .valido(valido_b), .listo(listo_b), .total(total_b),
        .ocupado(ocupado_b), .fin(fin_b));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Level-sensitive write model: memory takes dato_wr whenever LE is low.
    task automatic mem_write();
        if (!LE && dato_en) mem[dir] = dato_wr;
    endtask

    task automatic sweep(input bit load, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input bit clr, input int st_beat, input int st_len,
                         input int exp_fin, input logic [33:0] exp_tot, input bit rlist, input bit poke);
        logic [31:0] exp [3];
        int beat, cyc, left, fin_cyc, le_low;
        logic [1:0]  pdir, pvdir;
        logic [31:0] pval;
        bit          pheld;
        exp[0] = e0; exp[1] = e1; exp[2] = e2;
        if (load) for (int i = 0; i < 3; i++) mem[i] = exp[i];
        @(negedge clk); inicio = 1'b1; borrar = clr; listo = 1'b1;
        @(negedge clk); inicio = 1'b0; borrar = ~clr; cyc = 1;
        chk("ocupado_rise", 64'(ocupado), 64'd1);
        beat = 0; left = st_len; fin_cyc = 0; le_low = 0; pheld = 0; pdir = dir; pval = 0; pvdir = 0;
        while (fin_cyc == 0 && cyc < 300) begin
            if (cyc == 2) chk("first_beat_latency", 64'(valido), 64'd1);
            if (!LE) begin
                le_low++;
                chk("clear_cycle", {dato_en, dato_wr, dir}, {1'b1, 32'd0, pdir});
            end
            if (pheld) chk("beat_hold", {valido, valor_dir, valor}, {1'b1, pvdir, pval});
            if (fin) fin_cyc = cyc;
            inicio = poke && (cyc == 3 || fin);
            pheld = 0;
            if (valido) begin
                if (beat == st_beat && left > 0) begin listo = 1'b0; left--; end
                else listo = rlist ? 1'($urandom_range(0, 1)) : 1'b1;
                if (listo) begin
                    if (beat < 3) chk("beat", {valor_dir, valor}, {2'(beat), exp[beat]});
                    else chk("extra_beat", 64'(beat), 64'd2);
                    beat++;
                end else begin
                    pheld = 1; pval = valor; pvdir = valor_dir;
                end
            end else listo = rlist ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_write();
            pdir = dir;
            @(negedge clk); cyc++;
        end
        if (fin_cyc == 0) chk("fin_timeout", 64'd0, 64'd1);
        chk("beat_count", 64'(beat), 64'd3);
        chk("total", 64'(total), 64'(exp_tot));
        if (exp_fin > 0) chk("fin_cycle", 64'(fin_cyc), 64'(exp_fin));
        chk("le_low_cycles", 64'(le_low), clr ? 64'd3 : 64'd0);
        chk("after_fin", {ocupado, fin, valido}, 3'b000);
        inicio = 1'b0;
        if (poke) repeat (3) begin
            @(negedge clk);
            chk("no_restart", {ocupado, valido}, 2'b00);
        end
        chk("total_hold", 64'(total), 64'(exp_tot));
        for (int i = 0; i < 3; i++) chk("mem_after", 64'(mem[i]), clr ? 64'd0 : 64'(exp[i]));
    endtask

    typedef struct {
        bit          load;
        logic [31:0] m0, m1, m2;
        bit          clr;
        int          st_beat, st_len, fin;
        logic [33:0] tot;
        bit          poke;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int cyc, nb, fc;
        logic [31:0] r [3];
        bit clr;
        logic [33:0] tot;
        tbl[0] = '{1, 32'd5, 32'd1000, 32'hFFFF_FFFF, 0, -1, 0, 7,  34'h1_0000_03EC, 0};
        tbl[1] = '{1, 32'd5, 32'd1000, 32'hFFFF_FFFF, 0,  1, 4, 11, 34'h1_0000_03EC, 0};
        tbl[2] = '{1, 32'd5, 32'd1000, 32'hFFFF_FFFF, 1, -1, 0, 10, 34'h1_0000_03EC, 0};
        tbl[3] = '{0, 32'd0, 32'd0,    32'd0,         0, -1, 0, 7,  34'h0,           0};
        tbl[4] = '{1, 32'd5, 32'd1000, 32'hFFFF_FFFF, 0, -1, 0, 7,  34'h1_0000_03EC, 1};
        for (int i = 0; i < 4; i++) mem[i] = 32'd0;

        repeat (2) @(negedge clk);
        chk("reset_state", {dir, LE, dato_en, valido, ocupado, fin, total, valor, valor_dir},
            {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 34'd0, 32'd0, 2'd0});
        reset = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 5; t++)
            sweep(tbl[t].load, tbl[t].m0, tbl[t].m1, tbl[t].m2, tbl[t].clr, tbl[t].st_beat,
                  tbl[t].st_len, tbl[t].fin, tbl[t].tot, 0, tbl[t].poke);

        // Reset in the middle of beat 1 of a clearing sweep.
        mem[0] = 32'd5; mem[1] = 32'd1000; mem[2] = 32'hFFFF_FFFF;
        @(negedge clk); inicio = 1'b1; borrar = 1'b1; listo = 1'b1;
        @(negedge clk); inicio = 1'b0; cyc = 1;
        while (!(valido && valor_dir == 2'd1) && cyc < 20) begin
            mem_write();
            @(negedge clk); cyc++;
        end
        chk("reach_beat1", 64'(cyc), 64'd5);
        listo = 1'b0;
        #2 reset = 1'b1;
        #1 chk("async_reset", {LE, dato_en, valido, ocupado, total, dir}, {1'b1, 1'b0, 1'b0, 1'b0, 34'd0, 2'd0});
        @(negedge clk); reset = 1'b0; listo = 1'b1;
        chk("cntr1_kept", 64'(mem[1]), 64'd1000);
        sweep(0, 32'd0, 32'd1000, 32'hFFFF_FFFF, 0, -1, 0, 7, 34'h1_0000_03E7, 0, 0);

        // Single-counter instance.
        @(negedge clk); inicio_b = 1'b1;
        @(negedge clk); inicio_b = 1'b0; cyc = 1; nb = 0; fc = 0;
        while (fc == 0 && cyc < 20) begin
            if (valido_b) begin
                chk("single_beat", {valor_dir_b, valor_b}, {1'b0, 32'd42});
                nb++;
            end
            if (fin_b) fc = cyc;
            @(negedge clk); cyc++;
        end
        chk("single_fin_cycle", 64'(fc), 64'd3);
        chk("single_beats", 64'(nb), 64'd1);
        chk("single_total", 64'(total_b), 64'd42);

        // Randomized sweeps with random listo; expectations from a plain sum of the loaded counts.
        for (int k = 0; k < 8; k++) begin
            tot = 34'd0;
            for (int i = 0; i < 3; i++) begin
                case ($urandom_range(0, 3))
                    0:       r[i] = 32'd0;
                    1:       r[i] = 32'hFFFF_FFFF;
                    default: r[i] = $urandom;
                endcase
                tot = tot + 34'(r[i]);
            end
            clr = 1'($urandom_range(0, 1));
            sweep(1, r[0], r[1], r[2], clr, -1, 0, 0, tot, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
